// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port (A fetch, B data) arbiter onto one memory port; ARB_FIXED_PRIO_EN selects fixed B priority instead of round-robin
// Ports: clk/reset; port A a_req/a_addr/a_ack; port B b_req/b_we/b_addr/b_wdata/b_ack;
//        memory mem_req/mem_we/mem_addr/mem_wdata/mem_ready/mem_rdata; rdata to both ports; sel = registered owner
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic              sel
);
  typedef enum logic [1:0] {IDLE, BUSY_A, BUSY_B} state_t;
  state_t r_state;
  logic   r_sel;
  logic   w_tie_b;
  logic   w_grant_b;
`ifdef ARB_FIXED_PRIO_EN
  assign w_tie_b = 1'b1;
`else
  logic r_last;
  // r_last = 1 means B was granted last, so a tie goes to A
  assign w_tie_b = ~r_last;
  always_ff @(posedge clk)
    if (reset) r_last <= 1'b1;
    else if (r_state == IDLE && (a_req || b_req)) r_last <= w_grant_b;
`endif
  assign w_grant_b = b_req & (~a_req | w_tie_b);
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= IDLE;
      r_sel   <= 1'b0;
    end else if (r_state == IDLE) begin
      if (a_req || b_req) begin
        r_state <= w_grant_b ? BUSY_B : BUSY_A;
        r_sel   <= w_grant_b;
      end
    end else if (mem_ready) r_state <= IDLE;
  // acks are suppressed while reset is asserted so an abandoned access never completes
  assign a_ack     = (r_state == BUSY_A) & mem_ready & ~reset;
  assign b_ack     = (r_state == BUSY_B) & mem_ready & ~reset;
  assign mem_req   = r_state != IDLE;
  assign mem_we    = (r_state == BUSY_B) & b_we;
  assign mem_addr  = r_sel ? b_addr : a_addr;
  assign mem_wdata = r_sel ? b_wdata : '0;
  assign rdata     = mem_rdata;
  assign sel       = r_sel;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus randomized run against a transaction-level model
module tb_mem_port_arbiter;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset, a_req, b_req, b_we, mem_ready;
  logic [31:0] a_addr, b_addr, b_wdata, mem_rdata;
  logic        a_ack, b_ack, mem_req, mem_we, sel;
  logic [31:0] mem_addr, mem_wdata, rdata;
  int          total = 0;
  int          bad = 0;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .rdata(rdata), .sel(sel)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  typedef struct packed {
    logic rst, a, b, we, rdy;
    logic mreq, sel, aack, back, mwe;
  } vec_t;
  function automatic vec_t v(input logic rst, a, b, we, rdy, mreq, s, aack, back, mwe);
    return {rst, a, b, we, rdy, mreq, s, aack, back, mwe};
  endfunction
  vec_t tv[28];
  int   m_own, m_last, w;
  bit   m_sel;
  initial begin
    tv[0]  = v(0,1,0,0,0, 0,0,0,0,0);
    tv[1]  = v(0,1,0,0,1, 1,0,1,0,0);
    tv[2]  = v(0,0,0,0,0, 0,0,0,0,0);
    tv[3]  = v(0,0,1,1,0, 0,0,0,0,0);
    tv[4]  = v(0,0,1,1,0, 1,1,0,0,1);
    tv[5]  = v(0,0,1,1,1, 1,1,0,1,1);
    tv[6]  = v(0,0,0,0,0, 0,1,0,0,0);
    tv[7]  = v(0,0,0,0,1, 0,1,0,0,0);
    tv[8]  = v(0,0,0,0,1, 0,1,0,0,0);
    tv[9]  = v(0,1,0,0,0, 0,1,0,0,0);
    for (int i = 10; i < 15; i++) tv[i] = v(0,1,1,0,0, 1,0,0,0,0);
    tv[15] = v(0,1,1,0,1, 1,0,1,0,0);
    tv[16] = v(0,0,1,0,0, 0,0,0,0,0);
    tv[17] = v(0,0,1,0,0, 1,1,0,0,0);
    tv[18] = v(1,0,1,0,1, 1,1,0,0,0);
    tv[19] = v(0,1,1,0,0, 0,0,0,0,0);
    tv[20] = v(0,1,1,0,1, 1,FIXED,!FIXED,FIXED,0);
    tv[21] = v(0,1,1,0,1, 0,FIXED,0,0,0);
    tv[22] = v(0,1,1,0,1, 1,1,0,1,0);
    tv[23] = v(0,1,1,0,1, 0,1,0,0,0);
    tv[24] = v(0,1,1,0,1, 1,FIXED,!FIXED,FIXED,0);
    tv[25] = v(0,1,1,0,1, 0,FIXED,0,0,0);
    tv[26] = v(0,1,1,0,1, 1,1,0,1,0);
    tv[27] = v(0,0,0,0,0, 0,1,0,0,0);
    reset = 1'b1; a_req = 1'b0; b_req = 1'b0; b_we = 1'b0; mem_ready = 1'b0;
    a_addr = 32'h40; b_addr = 32'h100; b_wdata = 32'hDEAD_BEEF; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 mem_ready = 1'b1;
    @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 0);
    chk("rst_sel", {31'b0, sel}, 0);
    chk("rst_ack", {30'b0, a_ack, b_ack}, 0);
    chk("rst_mem_we", {31'b0, mem_we}, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 28; i++) begin
      {reset, a_req, b_req, b_we, mem_ready} = {tv[i].rst, tv[i].a, tv[i].b, tv[i].we, tv[i].rdy};
      mem_rdata = $urandom;
      @(negedge clk);
      chk($sformatf("v%0d_mem_req", i), {31'b0, mem_req}, {31'b0, tv[i].mreq});
      chk($sformatf("v%0d_sel", i), {31'b0, sel}, {31'b0, tv[i].sel});
      chk($sformatf("v%0d_a_ack", i), {31'b0, a_ack}, {31'b0, tv[i].aack});
      chk($sformatf("v%0d_b_ack", i), {31'b0, b_ack}, {31'b0, tv[i].back});
      chk($sformatf("v%0d_mem_we", i), {31'b0, mem_we}, {31'b0, tv[i].mwe});
      chk($sformatf("v%0d_rdata", i), rdata, mem_rdata);
      if (tv[i].mreq) chk($sformatf("v%0d_mem_addr", i), mem_addr, tv[i].sel ? 32'h100 : 32'h40);
      if (tv[i].mwe) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, 32'hDEAD_BEEF);
      @(posedge clk); #1;
    end
    // randomized phase: owner 0 = none, 1 = A, 2 = B; m_last holds the last granted port
    m_own = 0; m_last = 2; m_sel = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      reset     = (c == 0) || ($urandom_range(0, 59) == 0);
      a_req     = $urandom_range(0, 1) == 1;
      b_req     = $urandom_range(0, 1) == 1;
      b_we      = $urandom_range(0, 1) == 1;
      mem_ready = $urandom_range(0, 9) < 4;
      a_addr = $urandom; b_addr = $urandom; b_wdata = $urandom; mem_rdata = $urandom;
      @(negedge clk);
      if (c > 0) begin
        chk("rnd_mem_req", {31'b0, mem_req}, {31'b0, m_own != 0});
        chk("rnd_sel", {31'b0, sel}, {31'b0, m_sel});
        chk("rnd_a_ack", {31'b0, a_ack}, {31'b0, m_own == 1 && mem_ready && !reset});
        chk("rnd_b_ack", {31'b0, b_ack}, {31'b0, m_own == 2 && mem_ready && !reset});
        chk("rnd_mem_we", {31'b0, mem_we}, {31'b0, m_own == 2 && b_we});
        chk("rnd_rdata", rdata, mem_rdata);
        if (m_own == 1) chk("rnd_addr_a", mem_addr, a_addr);
        if (m_own == 2) chk("rnd_addr_b", mem_addr, b_addr);
        if (m_own == 2) chk("rnd_wdata", mem_wdata, b_wdata);
      end
      if (reset) begin
        m_own = 0; m_sel = 1'b0; m_last = 2;
      end else if (m_own == 0) begin
        if (a_req || b_req) begin
          w = (a_req && b_req) ? (FIXED ? 2 : (m_last == 2 ? 1 : 2)) : (a_req ? 1 : 2);
          m_own = w; m_sel = (w == 2); m_last = w;
        end
      end else if (mem_ready) m_own = 0;
      @(posedge clk); #1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
